// File: rtl/pk_gen_arbiter.sv
// pk_gen_arbiter
//   Shares one public_key_gen among N_REQ requesters. A round-robin pick
//   latches the winner's secret key and runs the generator in decipher mode.
//   The block then waits for ready, error or a timeout, and returns the result
//   over a valid/ready response channel.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request level, held until grant
//   req_seckey   packed secret keys, requester i at [8i+7:8i]
//   grant        one-hot, one-cycle accept pulse
//   busy         high whenever the sequencer is not idle
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_pk/rsp_err  requester index, public key (0 on error), status
//   kg_mode/kg_seckey      drive the shared generator
//   kg_pk/kg_ready/kg_err  generator results
//
// Every output comes straight from a register.

module pk_gen_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_seckey,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [7:0]         rsp_pk,
  output logic [1:0]         rsp_err,
  output logic [1:0]         kg_mode,
  output logic [7:0]         kg_seckey,
  input  logic [7:0]         kg_pk,
  input  logic               kg_ready,
  input  logic               kg_err
);

  localparam int              TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_KEY  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q;
  logic [1:0]         last_q;
  logic [1:0]         id_q;
  logic [N_REQ-1:0]   grant_q;
  logic               busy_q;
  logic               rsp_valid_q;
  logic [7:0]         rsp_pk_q;
  logic [1:0]         rsp_err_q;
  logic [1:0]         kg_mode_q;
  logic [7:0]         kg_key_q;
  logic [TW-1:0]      timer_q;

  // ---------------------------------------------------------------------------
  // Round-robin pick.
  // The request vector is doubled and shifted so that bit 0 of the rotated
  // vector is requester last_q+1. The lowest set bit is then the winner's
  // offset, and every array index stays a loop constant.
  // ---------------------------------------------------------------------------
  logic [2*N_REQ-1:0] req2, rot;
  logic               pick_vld;
  logic [2:0]         off, sum;
  logic [1:0]         pick_id;
  logic [N_REQ-1:0]   pick_oh;
  logic [7:0]         pick_key;

  always_comb begin
    req2     = {req, req};
    rot      = req2 >> (int'(last_q) + 1);
    pick_vld = 1'b0;
    off      = '0;
    // descending scan so the lowest offset is the last (winning) assignment
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pick_vld = 1'b1;
        off      = 3'(j);
      end
    end
    // last_q+1+off < 2*N_REQ, so a single wrap is enough
    sum = {1'b0, last_q} + 3'd1 + off;
    if (sum >= 3'(N_REQ)) sum = sum - 3'(N_REQ);
    pick_id  = sum[1:0];
    pick_oh  = '0;
    pick_key = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_vld && (pick_id == 2'(i))) begin
        pick_oh[i] = 1'b1;
        pick_key   = req_seckey[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
  // (ISSUE goes straight to RESP when the key is rejected.)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 2'(N_REQ - 1);   // requester 0 wins first after reset
      id_q        <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_pk_q    <= '0;
      rsp_err_q   <= ERR_OK;
      kg_mode_q   <= MODE_OFF;
      kg_key_q    <= '0;
      timer_q     <= '0;
    end else begin
      grant_q <= '0;                  // grant is a single-cycle pulse
      unique case (state_q)
        S_IDLE: begin
          kg_mode_q <= MODE_OFF;
          kg_key_q  <= '0;
          if (pick_vld) begin
            grant_q   <= pick_oh;
            kg_key_q  <= pick_key;
            kg_mode_q <= MODE_DEC;
            id_q      <= pick_id;
            last_q    <= pick_id;
            busy_q    <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // kg_err is combinational from kg_seckey and is valid already here
          if (kg_err) begin
            rsp_err_q   <= ERR_KEY;
            rsp_pk_q    <= '0;
            rsp_valid_q <= 1'b1;
            kg_mode_q   <= MODE_OFF;
            kg_key_q    <= '0;
            state_q     <= S_RESP;
          end else begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (kg_err) begin
            rsp_err_q   <= ERR_KEY;
            rsp_pk_q    <= '0;
            rsp_valid_q <= 1'b1;
            kg_mode_q   <= MODE_OFF;
            kg_key_q    <= '0;
            state_q     <= S_RESP;
          end else if (kg_ready) begin
            rsp_err_q   <= ERR_OK;
            rsp_pk_q    <= kg_pk;
            rsp_valid_q <= 1'b1;
            kg_mode_q   <= MODE_OFF;
            kg_key_q    <= '0;
            state_q     <= S_RESP;
          end else if (timer_q == T_LAST) begin
            rsp_err_q   <= ERR_TMO;
            rsp_pk_q    <= '0;
            rsp_valid_q <= 1'b1;
            kg_mode_q   <= MODE_OFF;
            kg_key_q    <= '0;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_RESP: begin
          // rsp_valid_q is always set in this state, so rsp_ready alone
          // completes the handshake. No arbitration happens here.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_pk    = rsp_pk_q;
  assign rsp_err   = rsp_err_q;
  assign kg_mode   = kg_mode_q;
  assign kg_seckey = kg_key_q;

endmodule

// File: tb/tb_pk_gen_arbiter.sv
// Directed bench for pk_gen_arbiter with a behavioural public_key_gen:
// keys 1..226 are valid, pk = (key - 2) mod 227, ready is registered, and
// err is combinational. A stub switch silences the generator for timeout cases.

module tb_pk_gen_arbiter;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_seckey;
  logic [N_REQ-1:0]   grant;
  logic               busy, rsp_valid, rsp_ready;
  logic [1:0]         rsp_id, rsp_err, kg_mode;
  logic [7:0]         rsp_pk, kg_seckey, kg_pk;
  logic               kg_ready, kg_err;

  int errs   = 0;
  int checks = 0;

  pk_gen_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_seckey(req_seckey),
    .grant(grant), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_pk(rsp_pk), .rsp_err(rsp_err),
    .kg_mode(kg_mode), .kg_seckey(kg_seckey), .kg_pk(kg_pk),
    .kg_ready(kg_ready), .kg_err(kg_err)
  );

  always #5 clk = ~clk;

  // generator model
  logic       stub;
  logic       g_rdy;
  logic [7:0] g_pk;
  logic       kvalid;
  assign kvalid = (kg_seckey != 8'd0) && (kg_seckey < 8'd227);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_rdy <= 1'b0;
      g_pk  <= 8'd0;
    end else begin
      g_rdy <= (kg_mode == 2'b01) && kvalid;
      g_pk  <= !kvalid ? 8'd0 : (kg_seckey >= 8'd2) ? kg_seckey - 8'd2 : kg_seckey + 8'd225;
    end
  end

  assign kg_ready = stub ? 1'b0 : g_rdy;
  assign kg_err   = stub ? 1'b0 : !kvalid;
  assign kg_pk    = g_pk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request: grant at cycle 1, response at cycle elat, then handshake.
  task automatic txn(input int idx, input logic [7:0] key, input logic [7:0] epk,
                     input logic [1:0] eerr, input int elat);
    int n;
    req_seckey[8*idx +: 8] = key;
    req = '0;
    req[idx] = 1'b1;
    step();
    chk("grant", 32'(grant), 32'(1 << idx));
    chk("busy_hi", 32'(busy), 1);
    chk("kg_mode_dec", 32'(kg_mode), 1);
    chk("kg_seckey", 32'(kg_seckey), 32'(key));
    req = '0;
    step();
    n = 2;
    chk("grant_pulse", 32'(grant), 0);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(elat));
    chk("rsp_id", 32'(rsp_id), 32'(idx));
    chk("rsp_pk", 32'(rsp_pk), 32'(epk));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    chk("kg_mode_off", 32'(kg_mode), 0);
    chk("kg_seckey_off", 32'(kg_seckey), 0);
    step();
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
    chk("busy_drop", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_id [4] = '{0, 1, 0, 1};
    rst_n = 1'b1; req = '0; req_seckey = '0; rsp_ready = 1'b1; stub = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_pk", 32'(rsp_pk), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_kg_mode", 32'(kg_mode), 0);
    chk("rst_kg_key", 32'(kg_seckey), 0);
    step();
    rst_n = 1'b1;

    // single requests, valid and invalid keys
    txn(0, 8'd10,  8'd8,   2'b00, 3);
    txn(0, 8'd226, 8'd224, 2'b00, 3);
    txn(0, 8'd1,   8'd226, 2'b00, 3);
    txn(0, 8'd0,   8'd0,   2'b01, 2);
    txn(0, 8'd227, 8'd0,   2'b01, 2);

    // backpressure with requester 1 queued behind requester 0
    rsp_ready = 1'b0;
    req_seckey = {8'd20, 8'd10};
    req = 2'b01;
    step();
    chk("bp_grant0", 32'(grant), 1);
    req = 2'b10;
    step();
    step();
    chk("bp_valid_rise", 32'(rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_pk", 32'(rsp_pk), 8);
      chk("bp_hold_id", 32'(rsp_id), 0);
      chk("bp_no_grant", 32'(grant), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle_valid", 32'(rsp_valid), 0);
    chk("bp_idle_grant", 32'(grant), 0);
    step();
    chk("bp_grant1", 32'(grant), 2);
    req = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("bp_rsp_id", 32'(rsp_id), 1);
    chk("bp_rsp_pk", 32'(rsp_pk), 18);
    step();

    // generator timeout
    stub = 1'b1;
    txn(0, 8'd10, 8'd0, 2'b10, TIMEOUT + 2);

    // asynchronous reset while in WAIT
    req_seckey[7:0] = 8'd10;
    req = 2'b01;
    step();
    req = '0;
    step();
    step();
    chk("mid_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_valid", 32'(rsp_valid), 0);
    chk("ar_kg_mode", 32'(kg_mode), 0);
    chk("ar_kg_key", 32'(kg_seckey), 0);
    chk("ar_err", 32'(rsp_err), 0);
    stub = 1'b0;
    req_seckey = {8'd20, 8'd10};
    req = 2'b11;
    #2 rst_n = 1'b1;
    step();
    chk("ar_first_grant", 32'(grant), 1);
    req = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("ar_rsp_pk", 32'(rsp_pk), 8);
    step();

    // round-robin with both requests held high
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_seckey = {8'd20, 8'd3};
    req = 2'b11;
    for (int e = 0; e < 4; e++) begin
      n = 0;
      do begin step(); n++; end while (grant == '0 && n < 10);
      chk("rr_gap", 32'(n), 1);
      chk("rr_grant", 32'(grant), 32'(1 << exp_id[e]));
      n = 0;
      while (!rsp_valid && n < 20) begin step(); n++; end
      chk("rr_rsp_id", 32'(rsp_id), 32'(exp_id[e]));
      chk("rr_rsp_pk", 32'(rsp_pk), (exp_id[e] == 0) ? 1 : 18);
      step();
    end
    req = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pk_gen_arbiter.md
Name: pk_gen_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one public_key_gen instance among N_REQ requesters.
- Latches a requester's secret key and drives the generator in decipher mode (2'b01).
- Waits for the generator's ready or error flag, with a timeout.
- Returns the public key, or an error code, to the requester over a valid/ready response handshake.

Parameters:
N_REQ, 2, number of requesters (2..4)
TIMEOUT, 8, WAIT-state cycles before declaring generator timeout (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, asynchronous active-low reset
req  input  N_REQ  per-requester request, level, held until grant
req_seckey  input  8*N_REQ  secret keys, requester i at bits [8i+7:8i]
grant  output  N_REQ  one-cycle accept pulse, one-hot
busy  output  1  high in any state other than IDLE
rsp_valid  output  1  response valid
rsp_ready  input  1  requester-side response accept
rsp_id  output  2  index of requester being answered
rsp_pk  output  8  public key (0 on error)
rsp_err  output  2  00 ok, 01 invalid secret key, 10 timeout
kg_mode  output  2  to public_key_gen mode
kg_seckey  output  8  to public_key_gen Secret_key
kg_pk  input  8  from public_key_gen Public_key
kg_ready  input  1  from public_key_gen P_K_ready (registered there)
kg_err  input  1  from public_key_gen err_invalid_seckey (combinational from kg_seckey)

Behaviour:
- Reset values: state IDLE; grant=0, busy=0, rsp_valid=0, rsp_id=0, rsp_pk=0, rsp_err=00, kg_mode=00, kg_seckey=0x00, timer=0.
- Reset sets the round-robin pointer last_id to N_REQ-1, so requester 0 wins first.
- All outputs are registered.
- IDLE:
  - kg_mode=00, kg_seckey=0.
  - If req!=0, select the first asserted index searching last_id+1, last_id+2, … modulo N_REQ.
  - On that edge: latch its key into kg_seckey, set kg_mode=01, record the index, update last_id to it, assert grant[idx]. Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - grant[idx]=1 this cycle only; kg_mode/kg_seckey held.
  - If kg_err=1: go to RESP with rsp_err=01, rsp_pk=0.
  - Otherwise go to WAIT with timer=0.
- WAIT:
  - kg_mode/kg_seckey held.
  - Priority order: kg_err=1 goes to RESP with err 01; else kg_ready=1 latches rsp_pk=kg_pk, rsp_err=00 and goes to RESP; else timer==TIMEOUT-1 goes to RESP with err 10, rsp_pk=0; else timer increments.
- RESP:
  - rsp_valid=1; rsp_id, rsp_pk, rsp_err stable.
  - kg_mode=00, kg_seckey=0 from RESP entry, which releases the generator.
  - Stays in RESP until rsp_valid & rsp_ready, then the next edge goes to IDLE with rsp_valid=0.
  - No new arbitration is possible in RESP.
- Nominal latency:
  - req high at edge 0 gives grant in cycle 1 (ISSUE).
  - With a real generator, kg_ready is seen in WAIT cycle 2.
  - rsp_valid rises in cycle 3.
  - With rsp_ready held high, back to IDLE at cycle 4; next grant in cycle 5.
- Requester contract:
  - Hold req and key stable until grant; drop req the cycle after grant.
  - A req still high after RESP is treated as a new request.
- Simultaneous requests: strictly round-robin; a requester never wins twice in a row while another is requesting.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation (any state): immediate return to reset values; the in-flight request is discarded with no response.
- Key range checking is delegated to the generator; no local key checks.
- Timer width: enough bits for TIMEOUT-1.

Test Plan:
- Single request: req[0]=1, key=10 → grant[0] in cycle 1, rsp_valid in cycle 3, rsp_id=0, rsp_pk=8, rsp_err=00; key=226 → rsp_pk=224; key=1 → rsp_pk=226.
- Invalid keys: key=0 and key=227 → grant pulse, then rsp_valid with rsp_err=01, rsp_pk=0; the generator sees kg_mode=00 after the response.
- Round-robin: req=2'b11 held continuously, keys 3 and 20 → service order 0,1,0,1; rsp_pk 1 and 18 alternating; no back-to-back repeats.
- Backpressure: hold rsp_ready=0 for 5 cycles with req[1] pending → rsp_valid and outputs stable, no grant[1] until 1 cycle after the response handshake completes.
- Timeout: stub generator with kg_ready=0, kg_err=0, TIMEOUT=8 → rsp_err=10 exactly 8 WAIT cycles after ISSUE, rsp_pk=0, busy drops after rsp_ready.
- Reset mid-WAIT: assert rst_n=0 asynchronously → all outputs zero without a clock edge; after release, req[0] is served first.
